mc_ctrl: RTL

Multi-cycle control unit for the MIPS core: the issuing end of the ALU `Func`/`sgn`/`err` interface. It sequences every instruction through fetch, decode, execute, memory and write-back. In each state it drives the ALU function code, the operand selects and the register/memory/PC enables. It consumes the ALU's `sgn` result for branches and its `err` result for overflow traps.

---
 rtl/mc_pkg.sv | 105 ++++++++++
 rtl/mc_ctrl_alu_dec.sv | 67 ++++++
 rtl/mc_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle MIPS control unit.
//   - ALU Func codes issued on alu_func
//   - opcode / funct values of the supported instruction set
//   - FSM state encoding, operand-select and PC-source encodings
//   - instruction classes produced by alu_dec, trap cause codes
package mc_pkg;

    // ALU Func codes
    localparam logic [5:0] FN_ADD   = 6'b000010;
    localparam logic [5:0] FN_SUB   = 6'b000100;
    localparam logic [5:0] FN_AND   = 6'b001000;
    localparam logic [5:0] FN_OR    = 6'b010000;
    localparam logic [5:0] FN_NOR   = 6'b100000;
    localparam logic [5:0] FN_XOR   = 6'b010001;
    localparam logic [5:0] FN_SLTU  = 6'b000101;
    localparam logic [5:0] FN_SLT   = 6'b001001;
    localparam logic [5:0] FN_PASSB = 6'b010010;
    localparam logic [5:0] FN_SRA   = 6'b011000;
    localparam logic [5:0] FN_SRL   = 6'b101000;
    localparam logic [5:0] FN_SLL   = 6'b110000;
    localparam logic [5:0] FN_BEQ   = 6'b000110;
    localparam logic [5:0] FN_BNE   = 6'b100001;

    // opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct values (IR[5:0])
    localparam logic [5:0] FT_SLL  = 6'h00;
    localparam logic [5:0] FT_SRL  = 6'h02;
    localparam logic [5:0] FT_SRA  = 6'h03;
    localparam logic [5:0] FT_ADD  = 6'h20;
    localparam logic [5:0] FT_ADDU = 6'h21;
    localparam logic [5:0] FT_SUB  = 6'h22;
    localparam logic [5:0] FT_SUBU = 6'h23;
    localparam logic [5:0] FT_AND  = 6'h24;
    localparam logic [5:0] FT_OR   = 6'h25;
    localparam logic [5:0] FT_XOR  = 6'h26;
    localparam logic [5:0] FT_NOR  = 6'h27;
    localparam logic [5:0] FT_SLT  = 6'h2A;
    localparam logic [5:0] FT_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_WB,
        ST_MEMADDR,
        ST_MEMRD,
        ST_MEMWR,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        A_PC    = 2'd0,
        A_RS    = 2'd1,
        A_SHAMT = 2'd2
    } a_sel_t;

    typedef enum logic [2:0] {
        B_RT       = 3'd0,
        B_FOUR     = 3'd1,
        B_SEXT     = 3'd2,
        B_SEXT_SH2 = 3'd3,
        B_ZEXT     = 3'd4,
        B_LUI      = 3'd5
    } b_sel_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_EXC    = 2'd3
    } pc_src_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_RSV
    } cls_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OVF  = 2'd1;
    localparam logic [1:0] CAUSE_RSV  = 2'd2;
    localparam logic [1:0] CAUSE_BUS  = 2'd3;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: combinational instruction decoder for mc_ctrl.
// Ports:
//   opcode, funct  in   instruction fields IR[31:26], IR[5:0]
//   func           out  ALU Func code for the execute/branch step
//   a_sel, b_sel   out  ALU operand selects for the execute/branch step
//   ovf_trap       out  instruction traps on ALU overflow (add, sub, addi)
//   reserved       out  unsupported opcode/funct
//   cls            out  instruction class used to route DECODE
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] func,
    output logic [1:0] a_sel,
    output logic [2:0] b_sel,
    output logic       ovf_trap,
    output logic       reserved,
    output cls_t       cls
);

    always_comb begin
        func     = FN_ADD;
        a_sel    = A_RS;
        b_sel    = B_RT;
        ovf_trap = 1'b0;
        reserved = 1'b0;
        cls      = CLS_R;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FT_ADD:  begin func = FN_ADD; ovf_trap = 1'b1; end
                FT_ADDU: func = FN_ADD;
                FT_SUB:  begin func = FN_SUB; ovf_trap = 1'b1; end
                FT_SUBU: func = FN_SUB;
                FT_AND:  func = FN_AND;
                FT_OR:   func = FN_OR;
                FT_XOR:  func = FN_XOR;
                FT_NOR:  func = FN_NOR;
                FT_SLT:  func = FN_SLT;
                FT_SLTU: func = FN_SLTU;
                // shift amount rides on port A, the shifted value (rt) on B
                FT_SLL:  begin func = FN_SLL; a_sel = A_SHAMT; end
                FT_SRL:  begin func = FN_SRL; a_sel = A_SHAMT; end
                FT_SRA:  begin func = FN_SRA; a_sel = A_SHAMT; end
                default: begin cls = CLS_RSV; reserved = 1'b1; end
            endcase
        end else begin
            cls = CLS_I;
            case (opcode)
                OP_ADDI:  begin b_sel = B_SEXT; ovf_trap = 1'b1; end
                OP_ADDIU: b_sel = B_SEXT;
                OP_SLTI:  begin func = FN_SLT;  b_sel = B_SEXT; end
                OP_SLTIU: begin func = FN_SLTU; b_sel = B_SEXT; end
                OP_ANDI:  begin func = FN_AND;  b_sel = B_ZEXT; end
                OP_ORI:   begin func = FN_OR;   b_sel = B_ZEXT; end
                OP_XORI:  begin func = FN_XOR;  b_sel = B_ZEXT; end
                OP_LUI:   begin func = FN_PASSB; b_sel = B_LUI; end
                OP_LW, OP_SW: begin cls = CLS_MEM; b_sel = B_SEXT; end
                OP_BEQ:   begin cls = CLS_BRANCH; func = FN_BEQ; end
                OP_BNE:   begin cls = CLS_BRANCH; func = FN_BNE; end
                OP_J:     cls = CLS_JUMP;
                default:  begin cls = CLS_RSV; reserved = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit, issuing end of the ALU Func/sgn/err
// interface.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       IR fields
//   alu_sgn, alu_err    ALU branch-compare result, add/sub overflow
//   mem_ready           memory completes current read/write
//   alu_func            ALU Func code
//   alu_a_sel           0=PC 1=rs 2=shamt
//   alu_b_sel           0=rt 1=4 2=sext imm 3=sext imm<<2 4=zext imm 5=imm<<16
//   iord                memory address 0=PC 1=ALUOut
//   mem_rd, mem_we      memory strobes, held until mem_ready
//   ir_we, pc_we, reg_we register enables
//   pc_src              0=ALU 1=ALUOut 2=jump target 3=exception vector
//   reg_dst, mem_to_reg write-back destination / source
//   exc_valid, exc_cause trap pulse, 1=overflow 2=reserved 3=bus timeout
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | ALUOut <= PC + (imm<<2), route by instruction class
// EXEC_R     | R-type ALU operation
// EXEC_I     | I-type ALU operation
// WB         | register file write
// MEMADDR    | ALUOut <= rs + sext imm
// MEMRD      | data read at ALUOut
// MEMWR      | data write at ALUOut
// BRANCH     | compare rs/rt, PC <= ALUOut when taken
// JUMP       | PC <= jump target
// TRAP       | PC <= exception vector, exc_valid pulse
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_sgn,
    input  logic       alu_err,
    input  logic       mem_ready,
    output logic [5:0] alu_func,
    output logic [1:0] alu_a_sel,
    output logic [2:0] alu_b_sel,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exc_valid,
    output logic [1:0] exc_cause
);

    localparam int              CW        = $clog2(WAIT_MAX + 1);
    // down-counter: the WAIT_MAX-th consecutive stalled cycle sees zero
    localparam logic [CW-1:0]   WAIT_LOAD = CW'(WAIT_MAX - 1);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic [1:0]    cause_q, cause_next;
    logic          mem_stall;

    logic [5:0]    dec_func;
    logic [1:0]    dec_a_sel;
    logic [2:0]    dec_b_sel;
    logic          dec_ovf_trap;
    logic          dec_reserved;
    cls_t          dec_cls;

    alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct    (funct),
        .func     (dec_func),
        .a_sel    (dec_a_sel),
        .b_sel    (dec_b_sel),
        .ovf_trap (dec_ovf_trap),
        .reserved (dec_reserved),
        .cls      (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            wait_cnt <= WAIT_LOAD;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            cause_q  <= cause_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        cause_next    = cause_q;
        mem_stall     = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_ready) state_next = ST_DECODE;
                else           mem_stall  = 1'b1;
            end
            ST_DECODE: begin
                if (dec_reserved) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_RSV;
                end else begin
                    case (dec_cls)
                        CLS_R:      state_next = ST_EXEC_R;
                        CLS_I:      state_next = ST_EXEC_I;
                        CLS_MEM:    state_next = ST_MEMADDR;
                        CLS_BRANCH: state_next = ST_BRANCH;
                        CLS_JUMP:   state_next = ST_JUMP;
                        default: begin
                            state_next = ST_TRAP;
                            cause_next = CAUSE_RSV;
                        end
                    endcase
                end
            end
            ST_EXEC_R, ST_EXEC_I: begin
                if (dec_ovf_trap && alu_err) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_OVF;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB:      state_next = ST_FETCH;
            ST_MEMADDR: state_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (mem_ready) state_next = ST_WB;
                else           mem_stall  = 1'b1;
            end
            ST_MEMWR: begin
                if (mem_ready) state_next = ST_FETCH;
                else           mem_stall  = 1'b1;
            end
            default:    state_next = ST_FETCH;
        endcase

        if (mem_stall) begin
            if (wait_cnt == '0) begin
                state_next = ST_TRAP;
                cause_next = CAUSE_BUS;
            end else begin
                wait_cnt_next = wait_cnt - CW'(1);
            end
        end
        if (state_next != state) wait_cnt_next = WAIT_LOAD;
    end

    // Outputs follow the state register; reset gates them immediately so an
    // access interrupted mid-instruction never completes on the next edge.
    always_comb begin
        alu_func   = '0;
        alu_a_sel  = '0;
        alu_b_sel  = '0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = '0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        exc_valid  = 1'b0;
        exc_cause  = '0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_a_sel = A_PC;
                    alu_b_sel = B_FOUR;
                    alu_func  = FN_ADD;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                    pc_src    = PC_ALU;
                end
                ST_DECODE: begin
                    alu_a_sel = A_PC;
                    alu_b_sel = B_SEXT_SH2;
                    alu_func  = FN_ADD;
                end
                ST_EXEC_R, ST_EXEC_I: begin
                    alu_func  = dec_func;
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (dec_cls == CLS_R);
                    mem_to_reg = (opcode == OP_LW);
                end
                ST_MEMADDR: begin
                    alu_a_sel = A_RS;
                    alu_b_sel = B_SEXT;
                    alu_func  = FN_ADD;
                end
                ST_MEMRD: begin
                    iord   = 1'b1;
                    mem_rd = 1'b1;
                end
                ST_MEMWR: begin
                    iord   = 1'b1;
                    mem_we = 1'b1;
                end
                ST_BRANCH: begin
                    alu_a_sel = A_RS;
                    alu_b_sel = B_RT;
                    alu_func  = dec_func;
                    pc_src    = PC_ALUOUT;
                    pc_we     = alu_sgn;
                end
                ST_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                end
                ST_TRAP: begin
                    exc_valid = 1'b1;
                    exc_cause = cause_q;
                    pc_we     = 1'b1;
                    pc_src    = PC_EXC;
                end
                default: begin
                    alu_func = '0;
                end
            endcase
        end
    end

endmodule
